// File: rtl/led_seq_pkg.sv
// ============================================================================
// Module   : led_seq_pkg
// Brief    : Shared encodings and helpers for the LED pattern sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_FILL_CLEAR = 2'd0,
        MODE_RUN_DOT    = 2'd1,
        MODE_FILL_DRAIN = 2'd2,
        MODE_BLINK      = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Step index must hold 0..2W (the longest period is FILL_DRAIN at 2W).
    function automatic int step_width(input int w);
        return $clog2(2 * w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_tick_gen.sv
// ============================================================================
// Module   : led_tick_gen
// Brief    : Prescaler producing a single-cycle step strobe every TICK_DIV clocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    input  logic EN,
    output logic TICK
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          w_last;

    assign w_last = (cnt_q == C_LAST);
    assign TICK   = EN && !CLR && w_last;

    always_comb begin
        cnt_d = cnt_q;
        if (CLR) begin
            cnt_d = '0;
        end else if (EN) begin
            cnt_d = w_last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
// ============================================================================
// Module   : led_pattern_sequencer
// Brief    : Steps an LED bank through four timed patterns, manual or auto-rotating.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 4,
    parameter int REPEAT   = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE_SEL,
    input  logic             AUTO,
    output logic [WIDTH-1:0] Q,
    output logic [1:0]       CUR_MODE,
    output logic             STEP_TICK,
    output logic             PAT_DONE
);

    localparam int SW = step_width(WIDTH);
    localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [SW-1:0] C_W     = SW'(WIDTH);
    localparam logic [RW-1:0] C_R_END = RW'(REPEAT - 1);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [SW-1:0]    step_q, step_d;
    logic [RW-1:0]    rep_q, rep_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic             w_run_en;
    logic             w_tick;
    mode_e            w_next_mode;

    // Shifting by s==WIDTH yields 0, so ~(ones << WIDTH) is all-ones without overflow.
    function automatic logic [WIDTH-1:0] frame(input mode_e m, input logic [SW-1:0] s);
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] one;
        ones  = '1;
        one   = {{(WIDTH-1){1'b0}}, 1'b1};
        frame = '0;
        case (m)
            MODE_FILL_CLEAR: frame = ~(ones << s);
            MODE_RUN_DOT:    frame = one << s;
            MODE_FILL_DRAIN: frame = (s <= C_W) ? ~(ones << s) : (ones >> (s - C_W));
            MODE_BLINK:      frame = (s == '0) ? '0 : ones;
            default:         frame = '0;
        endcase
    endfunction

    function automatic logic [SW-1:0] last_step(input mode_e m);
        last_step = '0;
        case (m)
            MODE_FILL_CLEAR: last_step = SW'(WIDTH);
            MODE_RUN_DOT:    last_step = SW'(WIDTH - 1);
            MODE_FILL_DRAIN: last_step = SW'(2 * WIDTH - 1);
            MODE_BLINK:      last_step = SW'(1);
            default:         last_step = '0;
        endcase
    endfunction

    assign w_run_en = (state_q == ST_RUN) && EN;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (!w_run_en),
        .EN   (w_run_en),
        .TICK (w_tick)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        step_d      = step_q;
        rep_d       = rep_q;
        q_d         = q_q;
        tick_d      = 1'b0;
        done_d      = 1'b0;
        w_next_mode = mode_q;

        case (state_q)
            ST_IDLE: begin
                if (EN) begin
                    state_d = ST_RUN;
                    mode_d  = mode_e'(MODE_SEL);
                    step_d  = '0;
                    rep_d   = '0;
                    q_d     = frame(mode_e'(MODE_SEL), '0);
                end
            end
            ST_RUN: begin
                if (!EN) begin
                    // Leaving RUN takes priority over any boundary on the same edge.
                    state_d = ST_IDLE;
                    step_d  = '0;
                    rep_d   = '0;
                    q_d     = '0;
                end else if (w_tick) begin
                    tick_d = 1'b1;
                    if (step_q == last_step(mode_q)) begin
                        done_d = 1'b1;
                        step_d = '0;
                        if (!AUTO) begin
                            w_next_mode = mode_e'(MODE_SEL);
                            rep_d       = '0;
                        end else if (rep_q == C_R_END) begin
                            w_next_mode = mode_e'(mode_q + 2'd1);
                            rep_d       = '0;
                        end else begin
                            rep_d = rep_q + RW'(1);
                        end
                        mode_d = w_next_mode;
                        q_d    = frame(w_next_mode, '0);
                    end else begin
                        step_d = step_q + SW'(1);
                        q_d    = frame(mode_q, step_q + SW'(1));
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_FILL_CLEAR;
            step_q  <= '0;
            rep_q   <= '0;
            q_q     <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            rep_q   <= rep_d;
            q_q     <= q_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign Q         = q_q;
    assign CUR_MODE  = mode_q;
    assign STEP_TICK = tick_q;
    assign PAT_DONE  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
// ============================================================================
// Module   : tb_led_pattern_sequencer
// Brief    : Directed and randomized checks of the LED sequencer against a pattern model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_sequencer;

    localparam int W        = 8;
    localparam int TICK_DIV = 4;
    localparam int REPEAT   = 2;

    logic         CLK;
    logic         RST;
    logic         EN;
    logic [1:0]   MODE_SEL;
    logic         AUTO;
    logic [W-1:0] Q;
    logic [1:0]   CUR_MODE;
    logic         STEP_TICK;
    logic         PAT_DONE;

    int n_checks;
    int n_errors;

    // Reference model state: counts in plain integers.
    bit m_run;
    int m_mode;
    int m_step;
    int m_presc;
    int m_rep;
    int m_q;
    bit m_tick;
    bit m_done;

    led_pattern_sequencer #(
        .WIDTH    (W),
        .TICK_DIV (TICK_DIV),
        .REPEAT   (REPEAT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .MODE_SEL  (MODE_SEL),
        .AUTO      (AUTO),
        .Q         (Q),
        .CUR_MODE  (CUR_MODE),
        .STEP_TICK (STEP_TICK),
        .PAT_DONE  (PAT_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int period_of(input int m);
        case (m)
            0:       return W + 1;
            1:       return W;
            2:       return 2 * W;
            default: return 2;
        endcase
    endfunction

    function automatic int frame_of(input int m, input int s);
        int full;
        full = (2 ** W) - 1;
        case (m)
            0:       return (2 ** s) - 1;
            1:       return 2 ** s;
            2:       return (s <= W) ? (2 ** s) - 1 : full / (2 ** (s - W));
            default: return (s % 2 == 1) ? full : 0;
        endcase
    endfunction

    function automatic void model_reset();
        m_run = 0; m_mode = 0; m_step = 0; m_presc = 0;
        m_rep = 0; m_q = 0; m_tick = 0; m_done = 0;
    endfunction

    function automatic void model_edge();
        m_tick = 0;
        m_done = 0;
        if (!m_run) begin
            if (EN) begin
                m_run = 1; m_mode = int'(MODE_SEL); m_step = 0;
                m_presc = 0; m_rep = 0; m_q = frame_of(m_mode, 0);
            end
        end else if (!EN) begin
            m_run = 0; m_step = 0; m_presc = 0; m_rep = 0; m_q = 0;
        end else if (m_presc == TICK_DIV - 1) begin
            m_presc = 0;
            m_tick  = 1;
            m_step  = m_step + 1;
            if (m_step == period_of(m_mode)) begin
                m_step = 0;
                m_done = 1;
                if (!AUTO) begin
                    m_mode = int'(MODE_SEL);
                    m_rep  = 0;
                end else begin
                    m_rep = m_rep + 1;
                    if (m_rep == REPEAT) begin
                        m_rep  = 0;
                        m_mode = (m_mode + 1) % 4;
                    end
                end
            end
            m_q = frame_of(m_mode, m_step);
        end else begin
            m_presc = m_presc + 1;
        end
    endfunction

    task automatic check_all();
        check_val("Q",         32'(Q),         32'(m_q));
        check_val("CUR_MODE",  32'(CUR_MODE),  32'(m_mode));
        check_val("STEP_TICK", 32'(STEP_TICK), 32'(m_tick));
        check_val("PAT_DONE",  32'(PAT_DONE),  32'(m_done));
    endtask

    task automatic cycle();
        @(posedge CLK);
        if (RST) model_edge();
        #1;
        check_all();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Drop reset between edges and confirm outputs clear without a clock.
    task automatic async_reset_pulse();
        #2;
        RST = 1'b0;
        #1;
        model_reset();
        check_all();
        run_cycles(2);
        RST = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RST      = 1'b0;
        EN       = 1'b0;
        MODE_SEL = 2'd0;
        AUTO     = 1'b0;
        model_reset();
        #1;
        check_all();
        run_cycles(3);
        RST = 1'b1;
        run_cycles(2);

        // FILL_CLEAR, then a mid-period request for RUN_DOT, then FILL_DRAIN.
        EN = 1'b1;
        run_cycles(20);
        MODE_SEL = 2'd1;
        run_cycles(50);
        MODE_SEL = 2'd2;
        run_cycles(100);

        // Auto rotation from BLINK wrapping back to FILL_CLEAR.
        EN = 1'b0;
        run_cycles(1);
        MODE_SEL = 2'd3;
        AUTO     = 1'b1;
        EN       = 1'b1;
        run_cycles(60);

        // EN drop mid-run and re-entry.
        AUTO     = 1'b0;
        MODE_SEL = 2'd0;
        EN = 1'b0;
        run_cycles(1);
        EN = 1'b1;
        run_cycles(22);
        EN = 1'b0;
        run_cycles(2);
        EN = 1'b1;
        run_cycles(10);

        async_reset_pulse();

        // EN falls on the very edge that would close a BLINK period.
        EN = 1'b0;
        run_cycles(1);
        MODE_SEL = 2'd3;
        EN       = 1'b1;
        run_cycles(8);
        MODE_SEL = 2'd1;
        EN       = 1'b0;
        run_cycles(3);
        EN = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            cycle();
            if ($urandom_range(0, 39) == 0) EN = ~EN;
            if ($urandom_range(0, 15) == 0) MODE_SEL = 2'($urandom);
            if ($urandom_range(0, 99) == 0) AUTO = ~AUTO;
            if ($urandom_range(0, 499) == 0) async_reset_pulse();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
